fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, AXI address width.
REQ-002 Parameter DATA_WIDTH, default 64, AXI read-data width; only 64 is supported.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset (reset==0 resets on the next posedge).
REQ-005 entry  input  64  program entry address, 8-byte aligned; sampled only during reset.
REQ-006 m_axi_araddr  output  ADDR_WIDTH  burst start address.
REQ-007 m_axi_arvalid  output  1; m_axi_arready  input  1  read-address handshake.
REQ-008 m_axi_arlen  output  8; m_axi_arsize  output  3; m_axi_arburst  output  2  burst shape.
REQ-009 m_axi_rdata  input  DATA_WIDTH; m_axi_rvalid  input  1; m_axi_rlast  input  1; m_axi_rready  output  1  read-data channel.
REQ-010 if_valid  output  1  one-cycle strobe: one fetched instruction is presented.
REQ-011 if_instr  output  32  fetched instruction word.
REQ-012 if_pc  output  64  byte address of if_instr.
REQ-013 halted  output  1  fetch stopped on an all-zero beat.
REQ-014 opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7  outputs  decoded fields of if_instr.
REQ-015 imm  output  64  sign-extended immediate.
REQ-016 itype  output  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.

Function
REQ-017 The fetch FSM SHALL have the states ADDR, DATA, ISSUE_LO, ISSUE_HI and HALT.
REQ-018 ADDR: arvalid=1 and araddr=pc; on arvalid&&arready go to DATA.
REQ-019 Burst constants SHALL be arlen=7, arsize=3'b011 and arburst=2'b01 (INCR), giving 8 beats of 8 bytes (64 bytes) per burst.
REQ-020 DATA: rready=1; rready=0 in all other states; on rvalid&&rready capture rdata and rlast, then go to ISSUE_LO, or to HALT if rdata==0.
REQ-021 ISSUE_LO: if_valid=1, if_instr=beat[31:0], if_pc=addr; next state ISSUE_HI.
REQ-022 ISSUE_HI: if_valid=1, if_instr=beat[63:32], if_pc=addr+4; addr advances by 8.
REQ-023 From ISSUE_HI, go to DATA if the captured rlast was 0; otherwise set pc=pc+64 and go to ADDR.
REQ-024 Latency: a beat accepted at edge N SHALL produce the low word at N+1 and the high word at N+2.
REQ-025 arvalid SHALL stay asserted until the handshake completes; araddr SHALL be stable while arvalid=1.
REQ-026 HALT: halted=1, arvalid=0, rready=0, if_valid=0; the state is terminal until reset.
REQ-027 Address arithmetic SHALL be modulo 2^64 (wrap-around).
REQ-028 Beats arriving without rvalid SHALL be ignored; rvalid outside DATA SHALL be held off by rready=0.
REQ-029 The decoder SHALL be purely combinational on if_instr; its outputs are valid whenever if_valid=1.
REQ-030 Field extraction: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
REQ-031 R format: opcodes 0110011 and 0111011; imm=0.
REQ-032 I format: opcodes 0010011, 0011011, 0000011 and 1100111; imm=sext([31:20]).
REQ-033 S format: opcode 0100011; imm=sext({[31:25],[11:7]}).
REQ-034 B format: opcode 1100011; imm=sext({[31],[7],[30:25],[11:8],0}).
REQ-035 U format: opcodes 0110111 and 0010111; imm=sext({[31:12],12'b0}).
REQ-036 J format: opcode 1101111; imm=sext({[31],[19:12],[20],[30:21],0}).
REQ-037 Any other opcode SHALL give itype=7 and imm=0; the other fields are still extracted.

Reset
REQ-038 While reset==0 at a posedge: state=ADDR, pc=addr=entry, arvalid=0, rready=0, if_valid=0, halted=0, captured beat=0.
REQ-039 Reset mid-burst SHALL abandon the burst; the first post-reset cycle is ADDR with arvalid=1 and araddr=entry, and outstanding beats are not consumed until DATA.

Verification
REQ-040 entry=0x1000, arready=1 -> arvalid for one cycle, araddr=0x1000, arlen=7, arsize=3, arburst=1.
REQ-041 Beat 0x00A00093_00500113 with rlast=0 -> if_instr=0x00500113 at pc 0x1000 (itype=1, rd=2, imm=5), next cycle 0x00A00093 at pc 0x1004 (rd=1, imm=10), then DATA.
REQ-042 8 beats with rlast on the 8th -> 16 if_valid strobes, pc 0x1000..0x103C; next araddr=0x1040.
REQ-043 if_instr 0xFE000EE3 -> itype=3, imm=-4 (0xFFFF_FFFF_FFFF_FFFC); 0x0000006F -> itype=5, imm=0; 0x00112623 -> itype=2, imm=12, rs2=1, rs1=2.
REQ-044 rdata=0 -> halted=1 next cycle, no if_valid, arvalid and rready remain 0.
REQ-045 reset=0 asserted during DATA after 3 beats -> after release, arvalid=1, araddr=entry, halted=0.

Source files
------------

// File: rtl/fetch_decode.sv
// fetch_decode: AXI read-burst instruction fetcher feeding a combinational RV64 field/immediate decoder
// Ports: clk, reset (sync, active-low), entry (start pc, sampled in reset);
//   m_axi_ar* / m_axi_r* AXI read master; if_valid/if_instr/if_pc fetched-word strobe;
//   halted (stopped on an all-zero beat); opcode/rd/rs1/rs2/funct3/funct7/imm/itype decoded fields.
module fetch_decode #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           entry,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rlast,
  output logic                  m_axi_rready,
  output logic                  if_valid,
  output logic [31:0]           if_instr,
  output logic [63:0]           if_pc,
  output logic                  halted,
  output logic [6:0]            opcode,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [63:0]           imm,
  output logic [2:0]            itype
);
  typedef enum logic [2:0] {ADDR, DATA, ISSUE_LO, ISSUE_HI, HALT} state_t;
  state_t state, state_n;
  logic [63:0] pc, addr;
  logic [DATA_WIDTH-1:0] beat;
  logic last;
  assign m_axi_araddr  = pc[ADDR_WIDTH-1:0];
  assign m_axi_arlen   = 8'd7;
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ADDR;
      pc    <= entry;
      addr  <= entry;
      beat  <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DATA && m_axi_rvalid) begin
        beat <= m_axi_rdata;
        last <= m_axi_rlast;
      end
      if (state == ISSUE_HI) begin
        addr <= addr + 64'd8;
        if (last) pc <= pc + 64'd64;
      end
    end
  end
  // Handshake strobes are gated by reset so nothing is requested or accepted while it is held.
  always_comb begin
    state_n       = state;
    m_axi_arvalid = reset && state == ADDR;
    m_axi_rready  = reset && state == DATA;
    if_valid      = reset && (state == ISSUE_LO || state == ISSUE_HI);
    halted        = state == HALT;
    if_instr      = state == ISSUE_HI ? beat[63:32] : beat[31:0];
    if_pc         = state == ISSUE_HI ? addr + 64'd4 : addr;
    case (state)
      ADDR:     state_n = m_axi_arready ? DATA : ADDR;
      DATA:     state_n = !m_axi_rvalid ? DATA : m_axi_rdata == '0 ? HALT : ISSUE_LO;
      ISSUE_LO: state_n = ISSUE_HI;
      ISSUE_HI: state_n = last ? ADDR : DATA;
      default:  state_n = HALT;
    endcase
  end
  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign funct7 = if_instr[31:25];
  always_comb begin
    itype = 3'd7;
    imm   = '0;
    case (opcode)
      7'b0110011, 7'b0111011: itype = 3'd0;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        itype = 3'd1;
        imm   = {{52{if_instr[31]}}, if_instr[31:20]};
      end
      7'b0100011: begin
        itype = 3'd2;
        imm   = {{52{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      7'b1100011: begin
        itype = 3'd3;
        imm   = {{51{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        itype = 3'd4;
        imm   = {{32{if_instr[31]}}, if_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        itype = 3'd5;
        imm   = {{43{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed bench for fetch_decode with a hand-driven AXI read slave
module tb_fetch_decode;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic [63:0] m_axi_araddr;
  logic        m_axi_arvalid, m_axi_arready;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, itype;
  logic [63:0] imm;
  int tests = 0;
  int fails = 0;
  int strobes = 0;
  logic [31:0] w [16] = '{
    32'h00500113, 32'h00A00093, 32'hFE000EE3, 32'h0000006F,
    32'h00112623, 32'h12345037, 32'h003100B3, 32'hFFFFFFFF,
    32'hFFF00513, 32'h800000EF, 32'h80000537, 32'h00008067,
    32'h00003083, 32'h80000063, 32'hFE112E23, 32'h0000003B};
  logic [2:0] ty [16] = '{3'd1, 3'd1, 3'd3, 3'd5, 3'd2, 3'd4, 3'd0, 3'd7,
                          3'd1, 3'd5, 3'd4, 3'd1, 3'd1, 3'd3, 3'd2, 3'd0};
  logic [63:0] im [16] = '{
    64'd5, 64'd10, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0,
    64'd12, 64'h0000_0000_1234_5000, 64'd0, 64'd0,
    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFF0_0000, 64'hFFFF_FFFF_8000_0000, 64'd0,
    64'd0, 64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0};
  fetch_decode dut (
    .clk(clk), .reset(reset), .entry(entry),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .halted(halted), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .itype(itype));
  always #5 clk = ~clk;
  always @(negedge clk) if (if_valid) strobes++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic burst_beat(input int k, input logic lst, input logic [63:0] base);
    m_axi_rdata  = {w[2*k+1], w[2*k]};
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = lst;
    step();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    for (int h = 0; h < 2; h++) begin
      chk("if_valid", if_valid, 1);
      chk("if_pc", if_pc, base + 64'(8 * k + 4 * h));
      chk("if_instr", if_instr, w[2*k+h]);
      chk("itype", itype, ty[2*k+h]);
      chk("imm", imm, im[2*k+h]);
      chk("fields", {funct7, rs2, rs1, funct3, rd, opcode}, w[2*k+h]);
      chk("issue_rready", m_axi_rready, 0);
      step();
    end
  endtask
  initial begin
    reset = 1'b0;
    entry = 64'h1000;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    step();
    step();
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_halted", halted, 0);
    reset = 1'b1;
    #1;
    chk("ar_valid", m_axi_arvalid, 1);
    chk("ar_addr", m_axi_araddr, 64'h1000);
    chk("ar_len", m_axi_arlen, 7);
    chk("ar_size", m_axi_arsize, 3);
    chk("ar_burst", m_axi_arburst, 1);
    step();
    chk("ar_hold_valid", m_axi_arvalid, 1);
    chk("ar_hold_addr", m_axi_araddr, 64'h1000);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    chk("ar_one_shot", m_axi_arvalid, 0);
    chk("data_rready", m_axi_rready, 1);
    step();
    chk("idle_if_valid", if_valid, 0);
    chk("idle_rready", m_axi_rready, 1);
    chk("first_rd", 64'(rd), 64'(rd));
    for (int k = 0; k < 8; k++) begin
      burst_beat(k, k == 7, 64'h1000);
      if (k == 0) begin
        chk("after_beat_rready", m_axi_rready, 1);
        chk("after_beat_arvalid", m_axi_arvalid, 0);
      end
    end
    chk("strobes", 64'(strobes), 16);
    chk("next_arvalid", m_axi_arvalid, 1);
    chk("next_araddr", m_axi_araddr, 64'h1040);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    for (int k = 0; k < 3; k++) burst_beat(k, 1'b0, 64'h1040);
    chk("mid_rready", m_axi_rready, 1);
    reset = 1'b0;
    entry = 64'h2000;
    m_axi_rdata = {w[7], w[6]};
    m_axi_rvalid = 1'b1;
    step();
    chk("mid_rst_arvalid", m_axi_arvalid, 0);
    chk("mid_rst_rready", m_axi_rready, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_arvalid", m_axi_arvalid, 1);
    chk("post_rst_araddr", m_axi_araddr, 64'h2000);
    chk("post_rst_halted", halted, 0);
    chk("post_rst_rready", m_axi_rready, 0);
    entry = 64'h3000;
    step();
    chk("entry_ignored", m_axi_araddr, 64'h2000);
    chk("held_off_if_valid", if_valid, 0);
    chk("held_off_rready", m_axi_rready, 0);
    m_axi_rvalid = 1'b0;
    reset = 1'b0;
    entry = 64'hFFFF_FFFF_FFFF_FFC0;
    step();
    reset = 1'b1;
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    burst_beat(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0);
    chk("wrap_arvalid", m_axi_arvalid, 1);
    chk("wrap_araddr", m_axi_araddr, 64'h0);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rvalid = 1'b1;
    step();
    chk("halt_halted", halted, 1);
    chk("halt_if_valid", if_valid, 0);
    chk("halt_arvalid", m_axi_arvalid, 0);
    chk("halt_rready", m_axi_rready, 0);
    m_axi_arready = 1'b1;
    m_axi_rdata = {w[1], w[0]};
    step();
    step();
    chk("halt_sticky", halted, 1);
    chk("halt_sticky_arvalid", m_axi_arvalid, 0);
    chk("halt_sticky_if_valid", if_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
